// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: scan states,
// active-low hex glyph table and a width helper.
package ssd_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } ssd_state_e;

  localparam logic [0:6] SEG_OFF_AL = 7'b1111111;

  // Glyphs are listed a..g left to right, 0 lights the segment.
  function automatic logic [0:6] hex_seg_al(input logic [3:0] nib);
    logic [0:6] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0001100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Ceiling log2, never below 1 so single-entry ranges still get a bit.
  function automatic int ssd_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ssd_hex_encode.sv
// Combinational nibble to segment pattern, a..g at index 0..6.
// Polarity selectable: SEG_ACTIVE_LOW=0 inverts the active-low glyph.
module ssd_hex_encode #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [0:6] seg
);
  import ssd_pkg::*;

  always_comb begin
    seg = SEG_ACTIVE_LOW ? hex_seg_al(nibble) : ~hex_seg_al(nibble);
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver with SHOW/BLANK scan, leading-zero
// suppression and a pending register that only lands on the frame boundary.
module ssd_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int GUARD          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int IW = ssd_pkg::ssd_clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_en,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_done
);
  import ssd_pkg::*;

  localparam int PMAX = (CLK_DIV > GUARD) ? CLK_DIV : GUARD;
  localparam int PW   = ssd_clog2(PMAX);
  localparam logic [PW-1:0] CLK_END   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IW-1:0] LAST      = IW'(NUM_DIGITS - 1);
  localparam logic [0:6]    SEG_OFF   = SEG_ACTIVE_LOW ? SEG_OFF_AL : ~SEG_OFF_AL;
  localparam logic          DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  ssd_state_e                state, state_nxt;
  logic [PW-1:0]             presc, presc_nxt;
  logic [IW-1:0]             idx_nxt;
  logic                      advance, wrap;

  logic [4*NUM_DIGITS-1:0]   pend_val, disp_val;
  logic [NUM_DIGITS-1:0]     pend_dp, disp_dp, pend_en, disp_en;

  logic [3:0]                nib;
  logic [0:6]                seg_enc, seg_d;
  logic                      dp_d, lit, zrun;
  logic [NUM_DIGITS-1:0]     supp, an_oh, an_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SHOW;
      presc      <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      digit_idx  <= idx_nxt;
      frame_done <= wrap;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc + 1'b1;
    idx_nxt   = digit_idx;
    advance   = 1'b0;
    case (state)
      SHOW: begin
        if (presc == CLK_END) begin
          presc_nxt = '0;
          if (GUARD > 0) state_nxt = BLANK;
          else           advance   = 1'b1;
        end
      end
      default: begin
        if (presc == GUARD_END) begin
          presc_nxt = '0;
          state_nxt = SHOW;
          advance   = 1'b1;
        end
      end
    endcase
    wrap = advance && (digit_idx == LAST);
    if (advance) idx_nxt = wrap ? '0 : digit_idx + 1'b1;
  end

  // A digit is blanked when it and every higher nibble are zero (digit 0 never).
  always_comb begin
    zrun = 1'b1;
    supp = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zrun    = zrun && (disp_val[4*k +: 4] == 4'd0);
      supp[k] = lz_en && zrun && (k != 0);
    end
  end

  always_comb begin
    nib = disp_val[4*digit_idx +: 4];
  end

  ssd_hex_encode #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_enc (
    .nibble(nib),
    .seg   (seg_enc)
  );

  always_comb begin
    lit              = (state == SHOW) && disp_en[digit_idx];
    an_oh            = '0;
    an_oh[digit_idx] = 1'b1;
    an_d             = lit ? (AN_ACTIVE_LOW ? ~an_oh : an_oh) : AN_OFF;
    seg_d            = (lit && !supp[digit_idx]) ? seg_enc : SEG_OFF;
    dp_d             = (lit && disp_dp[digit_idx]) ? ~DP_OFF : DP_OFF;
  end

  // A load coinciding with the wrap is forwarded straight into the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_en  <= '1;
      disp_val <= '0;
      disp_dp  <= '0;
      disp_en  <= '1;
      seg      <= SEG_OFF;
      dp       <= DP_OFF;
      an       <= AN_OFF;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_en  <= digit_en;
      end
      if (wrap) begin
        disp_val <= load ? value    : pend_val;
        disp_dp  <= load ? dp_in    : pend_dp;
        disp_en  <= load ? digit_en : pend_en;
      end
      seg <= seg_d;
      dp  <= dp_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: frame-position reference model plus directed
// scenarios and a randomized load/lz_en phase.
module tb_ssd_scan_driver;

  localparam int N       = 4;
  localparam int CLK_DIV = 4;
  localparam int GUARD   = 1;
  localparam int SLOT    = CLK_DIV + GUARD;
  localparam int FRAME   = N * SLOT;

  logic           clk;
  logic           rst_n;
  logic [4*N-1:0] value;
  logic           load;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   digit_en;
  logic           lz_en;
  logic [0:6]     seg;
  logic           dp;
  logic [N-1:0]   an;
  logic [1:0]     digit_idx;
  logic           frame_done;

  ssd_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(CLK_DIV), .GUARD(GUARD),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
    .digit_en(digit_en), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segtab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mn = edges since reset release; the scan position is pure arithmetic on it.
  int           mn;
  logic [4*N-1:0] m_pend, m_disp;
  logic [N-1:0] m_pdp, m_ddp, m_pen, m_den;
  logic [6:0]   exp_seg;
  logic         exp_dp, exp_fd;
  logic [N-1:0] exp_an;
  int           exp_idx;
  int           mp, md;
  bit           mshow;
  logic [4*N-1:0] hi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mn = 0;
      m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0; m_pen = '1; m_den = '1;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = '1; exp_idx = 0; exp_fd = 1'b0;
    end else begin
      mp    = mn % FRAME;
      md    = mp / SLOT;
      mshow = (mp % SLOT) < CLK_DIV;
      if (mshow && m_den[md]) begin
        exp_an = ~(N'(1) << md);
        exp_dp = ~m_ddp[md];
        hi     = m_disp >> (4 * md);
        exp_seg = (lz_en && md != 0 && hi == 0) ? 7'h7F : segtab[hi[3:0]];
      end else begin
        exp_an = '1; exp_dp = 1'b1; exp_seg = 7'h7F;
      end
      mn = mn + 1;
      exp_fd  = (mn % FRAME) == 0;
      exp_idx = (mn % FRAME) / SLOT;
      if (load) begin
        m_pend = value; m_pdp = dp_in; m_pen = digit_en;
      end
      if (exp_fd) begin
        m_disp = m_pend; m_ddp = m_pdp; m_den = m_pen;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("digit_idx", 32'(digit_idx), 32'(exp_idx));
      check("frame_done", 32'(frame_done), 32'(exp_fd));
    end
  end

  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (mn < target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("wait_n", 32'(mn), 32'(target));
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    value = v; dp_in = d; digit_en = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; value = '0; load = 1'b0; dp_in = '0; digit_en = '1; lz_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h0000007F);
    rst_n = 1'b1;

    // Zero display, digit 0 lit, upper digits blanked by leading-zero suppression.
    wait_n(1);
    check("t1_an0", 32'(an), 32'b1110);
    check("t1_seg0", 32'(seg), 32'b0000001);
    wait_n(7);
    check("t1_an1", 32'(an), 32'b1101);
    check("t1_seg1", 32'(seg), 32'b1111111);

    // Mid-frame load must not tear the current frame.
    load_once(16'h12AF, 4'b0000, 4'b1111);
    wait_n(12);
    check("t2_hold", 32'(seg), 32'b1111111);
    wait_n(20);
    check("t2_fd", 32'(frame_done), 32'd1);
    wait_n(21);
    check("t2_dig0", 32'(seg), 32'b0111000);
    wait_n(26);
    check("t2_dig1", 32'(seg), 32'b0001000);

    load_once(16'h0050, 4'b1000, 4'b1111);
    wait_n(56);
    check("t3_seg3", 32'(seg), 32'b1111111);
    check("t3_dp3", 32'(dp), 32'd0);
    check("t3_an3", 32'(an), 32'b0111);
    lz_en = 1'b0;
    wait_n(59);
    check("t3_nolz", 32'(seg), 32'b0000001);

    // Load exactly on the wrap edge is taken by the display immediately.
    load_once(16'hBEEF, 4'b0000, 4'b1111);
    check("t5_at", 32'(mn), 32'd60);
    wait_n(61);
    check("t5_seg", 32'(seg), 32'b0111000);

    load_once(16'hBEEF, 4'b0000, 4'b0101);
    wait_n(81);
    check("t4_an0", 32'(an), 32'b1110);
    wait_n(87);
    check("t4_an1", 32'(an), 32'b1111);

    // Async reset in the middle of digit 2's SHOW slot.
    wait_n(112);
    #2 rst_n = 1'b0;
    #1;
    check("t6_an", 32'(an), 32'b1111);
    check("t6_seg", 32'(seg), 32'b1111111);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_n(1);
    check("t6_an0", 32'(an), 32'b1110);
    check("t6_seg0", 32'(seg), 32'b0000001);
    check("t6_idx", 32'(digit_idx), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      value    = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      dp_in    = 4'($urandom);
      digit_en = 4'($urandom);
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      @(negedge clk);
    end
    load = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
